// File: rtl/mem_stage.sv
// MEM stage: fixed-latency data-memory access, branch resolution and the MEM/WB register.
// A multi-cycle access holds the upstream stages through `stall` until the access completes.
module mem_stage #(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic                  Zero,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           write_data,
    input  logic [31:0]           branch_target,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic [4:0]            write_reg,
    output logic                  PCSrc,
    output logic [31:0]           branch_target_o,
    output logic                  stall,
    output logic [31:0]           read_data_o,
    output logic [31:0]           alu_result_o,
    output logic [4:0]            write_reg_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic                  misaligned_o,
    output logic                  state_dbg,
    output logic [3:0]            cnt_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAST   = 4'(MEM_LATENCY - 1);
    localparam logic       SINGLE = (MEM_LATENCY == 1);

    state_e                  state;
    logic [3:0]              cnt;
    logic [31:0]             mem [0:DEPTH-1] = '{default: 32'h0};

    logic                    req;
    logic                    misaligned;
    logic                    aligned_req;
    logic                    complete;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [31:0]             mem_word;

    assign PCSrc           = Branch & Zero;
    assign branch_target_o = branch_target;
    assign state_dbg       = (state == BUSY);
    assign cnt_dbg         = cnt;

    // Stall contract: while stall=1 the upstream stages and PC hold, so the
    // EX/MEM inputs stay stable until the cycle in which the access completes.
    always_comb begin
        req         = MemRead | MemWrite;
        misaligned  = req & (alu_result[1:0] != 2'b00);
        aligned_req = req & ~misaligned;
        word_idx    = alu_result[ADDR_WIDTH+1:2];
        mem_word    = mem[word_idx];
        complete    = ((state == IDLE) & req & SINGLE) |
                      ((state == BUSY) & (cnt == LAST));
        stall       = aligned_req & ~complete & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned_req && !SINGLE) begin
                        state <= BUSY;
                        cnt   <= 4'd1;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Stores commit only on the completing edge; a reset mid-access drops them.
    always_ff @(posedge clk) begin
        if (!reset && complete && aligned_req && MemWrite) begin
            mem[word_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            read_data_o  <= 32'h0;
            alu_result_o <= 32'h0;
            write_reg_o  <= 5'd0;
            RegWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            read_data_o  <= (aligned_req && MemRead && !MemWrite) ? mem_word : 32'h0;
            alu_result_o <= alu_result;
            write_reg_o  <= write_reg;
            RegWrite_o   <= RegWrite & ~misaligned;
            MemtoReg_o   <= MemtoReg;
            misaligned_o <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a latency-2 and a latency-4 instance, table vectors,
// hand-written reset-mid-access sequence and randomized ops against a reference model.
module tb_mem_stage;

    localparam int AW = 8;

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic        br;
        logic        z;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] bt;
        logic        rw;
        logic        mtr;
        logic [4:0]  wr;
    } in_t;

    typedef struct {
        int          stalls;
        logic        pcsrc;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
        logic        mis;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    typedef struct {
        logic        pcsrc;
        logic        stall;
        logic        rw;
        logic        mtr;
        logic        mis;
        logic [31:0] bto;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    in_t  in_a, in_b;

    logic        pcsrc_a, stall_a, rw_a, mtr_a, mis_a, st_a;
    logic [31:0] bto_a, rd_a, alu_a;
    logic [4:0]  wr_a;
    logic [3:0]  cnt_a;
    logic        pcsrc_b, stall_b, rw_b, mtr_b, mis_b, st_b;
    logic [31:0] bto_b, rd_b, alu_b;
    logic [4:0]  wr_b;
    logic [3:0]  cnt_b;

    mem_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_a),
        .MemRead(in_a.mr), .MemWrite(in_a.mw), .Branch(in_a.br), .Zero(in_a.z),
        .alu_result(in_a.addr), .write_data(in_a.wd), .branch_target(in_a.bt),
        .RegWrite(in_a.rw), .MemtoReg(in_a.mtr), .write_reg(in_a.wr),
        .PCSrc(pcsrc_a), .branch_target_o(bto_a), .stall(stall_a),
        .read_data_o(rd_a), .alu_result_o(alu_a), .write_reg_o(wr_a),
        .RegWrite_o(rw_a), .MemtoReg_o(mtr_a), .misaligned_o(mis_a),
        .state_dbg(st_a), .cnt_dbg(cnt_a)
    );

    mem_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(4)) dut_b (
        .clk(clk), .reset(rst_b),
        .MemRead(in_b.mr), .MemWrite(in_b.mw), .Branch(in_b.br), .Zero(in_b.z),
        .alu_result(in_b.addr), .write_data(in_b.wd), .branch_target(in_b.bt),
        .RegWrite(in_b.rw), .MemtoReg(in_b.mtr), .write_reg(in_b.wr),
        .PCSrc(pcsrc_b), .branch_target_o(bto_b), .stall(stall_b),
        .read_data_o(rd_b), .alu_result_o(alu_b), .write_reg_o(wr_b),
        .RegWrite_o(rw_b), .MemtoReg_o(mtr_b), .misaligned_o(mis_b),
        .state_dbg(st_b), .cnt_dbg(cnt_b)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [2][256];
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(logic mr, logic mw, logic br, logic z, logic [31:0] addr,
                                  logic [31:0] wd, logic [31:0] bt, logic rw, logic mtr,
                                  logic [4:0] wr);
        in_t v;
        v = '{mr, mw, br, z, addr, wd, bt, rw, mtr, wr};
        return v;
    endfunction

    function automatic exp_t mk_exp(int stalls, logic pcsrc, logic [31:0] rd, logic [31:0] alu,
                                    logic [4:0] wr, logic rw, logic mtr, logic mis);
        exp_t e;
        e = '{stalls, pcsrc, rd, alu, wr, rw, mtr, mis};
        return e;
    endfunction

    // Reference behaviour from the architectural rules: latency, misalignment, word memory.
    function automatic exp_t model_step(int sel, in_t v);
        exp_t e;
        int   lat = (sel == 0) ? 2 : 4;
        logic req = v.mr | v.mw;
        logic mis = req && (v.addr[1:0] != 2'b00);
        int   idx = int'(v.addr[AW+1:2]);
        e.pcsrc  = v.br & v.z;
        e.alu    = v.addr;
        e.wr     = v.wr;
        e.mtr    = v.mtr;
        e.rw     = v.rw & ~mis;
        e.mis    = mis;
        e.stalls = (req && !mis) ? lat - 1 : 0;
        e.rd     = 32'h0;
        if (req && !mis) begin
            if (v.mw) model_mem[sel][idx] = v.wd;
            else      e.rd = model_mem[sel][idx];
        end
        return e;
    endfunction

    function automatic out_t cur(int sel);
        out_t o;
        if (sel == 0) o = '{pcsrc_a, stall_a, rw_a, mtr_a, mis_a, bto_a, rd_a, alu_a, wr_a};
        else          o = '{pcsrc_b, stall_b, rw_b, mtr_b, mis_b, bto_b, rd_b, alu_b, wr_b};
        return o;
    endfunction

    task automatic drive(input int sel, input in_t v);
        if (sel == 0) in_a = v;
        else          in_b = v;
    endtask

    // Entered just after a rising edge; leaves just after the edge where the result is visible.
    task automatic do_op(input int sel, input string name, input in_t v, input exp_t e);
        out_t o;
        int   stalls = 0;
        bit   done = 0;
        drive(sel, v);
        @(negedge clk);
        o = cur(sel);
        check({name, ".pcsrc"}, 32'(o.pcsrc), 32'(e.pcsrc));
        check({name, ".bt"}, o.bto, v.bt);
        for (int k = 0; k < 20 && !done; k++) begin
            o = cur(sel);
            if (o.stall) begin
                stalls++;
                @(posedge clk); #1;
                o = cur(sel);
                check({name, ".bubble"}, o.rd | o.alu | 32'(o.wr) | 32'({o.rw, o.mtr, o.mis}), 32'h0);
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s.timeout actual=stall_stuck required=completion", name);
        end
        check({name, ".stalls"}, 32'(stalls), 32'(e.stalls));
        @(posedge clk); #1;
        o = cur(sel);
        check({name, ".rd"}, o.rd, e.rd);
        check({name, ".alu"}, o.alu, e.alu);
        check({name, ".wr"}, 32'(o.wr), 32'(e.wr));
        check({name, ".ctl"}, 32'({o.rw, o.mtr, o.mis}), 32'({e.rw, e.mtr, e.mis}));
        drive(sel, '0);
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.mr   = 1'($urandom_range(0, 1));
        v.mw   = 1'($urandom_range(0, 1));
        v.br   = 1'($urandom_range(0, 1));
        v.z    = 1'($urandom_range(0, 1));
        v.addr = ($urandom & 32'hFFFF_FC3C) |
                 (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        v.wd   = $urandom;
        v.bt   = $urandom;
        v.rw   = 1'($urandom_range(0, 1));
        v.mtr  = 1'($urandom_range(0, 1));
        v.wr   = 5'($urandom_range(0, 31));
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  v;
        exp_t e;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 256; w++) model_mem[s][w] = 32'h0;

        vecs[0]  = '{mk_in(0,1,1,1,32'h10,32'hDEADBEEF,32'h400,0,0,0),  mk_exp(1,1,32'h0,32'h10,0,0,0,0)};
        vecs[1]  = '{mk_in(1,0,1,0,32'h10,32'h0,32'h44,1,1,5),          mk_exp(1,0,32'hDEADBEEF,32'h10,5,1,1,0)};
        vecs[2]  = '{mk_in(0,0,0,1,32'h1234,32'h0,32'h88,1,0,3),        mk_exp(0,0,32'h0,32'h1234,3,1,0,0)};
        vecs[3]  = '{mk_in(0,1,1,1,32'h13,32'h11111111,32'h8,1,0,2),    mk_exp(0,1,32'h0,32'h13,2,0,0,1)};
        vecs[4]  = '{mk_in(1,0,0,0,32'h10,32'h0,32'h0,1,1,7),           mk_exp(1,0,32'hDEADBEEF,32'h10,7,1,1,0)};
        vecs[5]  = '{mk_in(0,1,0,0,32'h400,32'hA5A5A5A5,32'h0,0,0,0),   mk_exp(1,0,32'h0,32'h400,0,0,0,0)};
        vecs[6]  = '{mk_in(1,0,0,0,32'h0,32'h0,32'h0,1,1,9),            mk_exp(1,0,32'hA5A5A5A5,32'h0,9,1,1,0)};
        vecs[7]  = '{mk_in(1,0,0,0,32'h12,32'h0,32'h0,1,1,4),           mk_exp(0,0,32'h0,32'h12,4,0,1,1)};
        vecs[8]  = '{mk_in(1,1,0,0,32'h20,32'h77,32'h0,1,0,6),          mk_exp(1,0,32'h0,32'h20,6,1,0,0)};
        vecs[9]  = '{mk_in(1,0,0,0,32'h20,32'h0,32'h0,1,1,8),           mk_exp(1,0,32'h77,32'h20,8,1,1,0)};
        vecs[10] = '{mk_in(1,0,0,0,32'h3FC,32'h0,32'h0,1,1,1),          mk_exp(1,0,32'h0,32'h3FC,1,1,1,0)};
        vecs[11] = '{mk_in(0,1,0,0,32'h3FC,32'hFFFFFFFF,32'h0,0,0,0),   mk_exp(1,0,32'h0,32'h3FC,0,0,0,0)};
        vecs[12] = '{mk_in(1,0,0,0,32'h7FC,32'h0,32'h0,1,1,12),         mk_exp(1,0,32'hFFFFFFFF,32'h7FC,12,1,1,0)};

        rst_a = 1'b1;
        rst_b = 1'b1;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        in_a = mk_in(1,0,0,0,32'h10,32'h0,32'h0,1,1,5);
        @(negedge clk);
        check("rst.stall_a", 32'(stall_a), 32'h0);
        @(posedge clk); #1;
        check("rst.outs_a", rd_a | alu_a | 32'(wr_a) | 32'({rw_a, mtr_a, mis_a}), 32'h0);
        check("rst.fsm_a", 32'({st_a, cnt_a}), 32'h0);
        check("rst.outs_b", rd_b | alu_b | 32'(wr_b) | 32'({rw_b, mtr_b, mis_b, stall_b}), 32'h0);
        check("rst.fsm_b", 32'({st_b, cnt_b}), 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        in_a  = '0;
        @(negedge clk);
        check("idle.stall", 32'(stall_a), 32'h0);
        check("idle.pcsrc", 32'(pcsrc_a), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            void'(model_step(0, vecs[i].i));
            do_op(0, $sformatf("vec%0d", i), vecs[i].i, vecs[i].e);
        end

        for (int i = 0; i < 60; i++) begin
            v = rand_in();
            e = model_step(0, v);
            do_op(0, "rand_a", v, e);
        end

        // Latency 4: reset lands in the second stall cycle of a store to 0x20.
        in_b = mk_in(0,1,0,0,32'h20,32'hCAFEF00D,32'h0,0,0,0);
        @(negedge clk);
        check("b_rst.stall_t0", 32'(stall_b), 32'h1);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        check("b_rst.stall_in_reset", 32'(stall_b), 32'h0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        in_b  = '0;
        check("b_rst.fsm", 32'({st_b, cnt_b}), 32'h0);
        check("b_rst.outs", rd_b | alu_b | 32'(wr_b) | 32'({rw_b, mtr_b, mis_b}), 32'h0);
        v = mk_in(1,0,0,0,32'h20,32'h0,32'h0,1,1,10);
        void'(model_step(1, v));
        do_op(1, "b_load20", v, mk_exp(3,0,32'h0,32'h20,10,1,1,0));
        v = mk_in(0,1,1,1,32'h24,32'h12345678,32'h99,0,0,0);
        void'(model_step(1, v));
        do_op(1, "b_store24", v, mk_exp(3,1,32'h0,32'h24,0,0,0,0));
        v = mk_in(1,0,0,0,32'h24,32'h0,32'h0,1,1,11);
        void'(model_step(1, v));
        do_op(1, "b_load24", v, mk_exp(3,0,32'h12345678,32'h24,11,1,1,0));

        for (int i = 0; i < 25; i++) begin
            v = rand_in();
            e = model_step(1, v);
            do_op(1, "rand_b", v, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
